// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed byte stream into word writes and holds the core until the image is in.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_SIZE = 10,
    parameter int DATA_SIZE = 32
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 imem_we,
    output logic [ADDR_SIZE-1:0] imem_waddr,
    output logic [DATA_SIZE-1:0] imem_wdata,
    output logic                 core_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int BPW   = DATA_SIZE / 8;
    localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int DEPTH = 1 << ADDR_SIZE;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM   = 3'd5,
`endif
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_t;

    state_t               state, state_next, after_last;
    logic                 accept, last_byte, last_word, load_start;
    logic                 ready_next, busy_next;
    logic [15:0]          len, n_full;
    logic [ADDR_SIZE:0]   word_cnt;
    logic [BCW-1:0]       byte_cnt;
    logic [DATA_SIZE-1:0] word_buf, word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    assign accept     = byte_valid && byte_ready;
    assign last_byte  = (byte_cnt == BCW'(BPW - 1));
    assign last_word  = ((32'(word_cnt) + 32'd1) == 32'(len));
    assign n_full     = {byte_data, len[7:0]};
    assign load_start = (state_next == LEN_LO) && (state != LEN_LO);

    // Little-endian insertion of the incoming byte into the word being assembled.
    always_comb begin
        word_next = word_buf;
        for (int k = 0; k < BPW; k++) begin
            if (byte_cnt == BCW'(k)) word_next[8*k +: 8] = byte_data;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
`ifdef IMEM_LOADER_CHECKSUM_EN
        after_last = CSUM;
`else
        after_last = DONE;
`endif
        case (state)
            IDLE, DONE, ERROR: if (start) state_next = LEN_LO;
            LEN_LO:            if (accept) state_next = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (32'(n_full) > 32'(DEPTH)) state_next = ERROR;
                    else if (n_full == 16'd0)     state_next = after_last;
                    else                          state_next = DATA;
                end
            end
            DATA:  if (accept && last_byte) state_next = WRITE;
            WRITE: state_next = last_word ? after_last : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:  if (accept) state_next = (byte_data == csum) ? DONE : ERROR;
`endif
            default: state_next = IDLE;
        endcase

        ready_next = 1'b0;
        case (state_next)
            LEN_LO, LEN_HI, DATA: ready_next = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:                 ready_next = 1'b1;
`endif
            default:              ready_next = 1'b0;
        endcase
        busy_next = !(state_next inside {IDLE, DONE, ERROR});
    end

    // Status outputs are registered from the next state so they change on the same edge as the state.
    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            core_hold  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_next;
            byte_ready <= ready_next;
            imem_we    <= (state_next == WRITE);
            core_hold  <= (state_next != DONE);
            busy       <= busy_next;
            done       <= (state_next == DONE);
            error      <= (state_next == ERROR);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            len        <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            imem_waddr <= '0;
            imem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else if (load_start) begin
            word_cnt <= '0;
            byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept) csum <= csum ^ byte_data;
`endif
            if (accept && state == LEN_LO) len[7:0]  <= byte_data;
            if (accept && state == LEN_HI) len[15:8] <= byte_data;
            if (accept && state == DATA) begin
                word_buf <= word_next;
                if (last_byte) begin
                    byte_cnt   <= '0;
                    imem_waddr <= word_cnt[ADDR_SIZE-1:0];
                    imem_wdata <= word_next;
                end else begin
                    byte_cnt <= byte_cnt + BCW'(1);
                end
            end
            if (state == WRITE) word_cnt <= word_cnt + (ADDR_SIZE+1)'(1);
        end
    end

endmodule
